console_writer: RTL and testbench
=================================

CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 Parameter COLS, default 50, characters per text row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter BLANK, default 8'h20, fill byte for clears and backspace.
REQ-004 CLK_CPU  in  1  sole clock; all logic on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 char_valid  in  1  producer offers char_data this cycle.
REQ-007 char_data  in  8  ASCII byte or control code.
REQ-008 char_ready  out  1  block accepts a byte this cycle.
REQ-009 video_write_enable  out  1  one-cycle write strobe into video memory.
REQ-010 video_write_data  out  8  byte written.
REQ-011 video_write_addr  out  11  linear cell address, row*COLS+col, range 0..1499.
REQ-012 cursor_col  out  6  current column, 0..COLS-1.
REQ-013 cursor_row  out  5  current row, 0..ROWS-1.
REQ-014 busy  out  1  high in any clear state.

Function
REQ-015 The block SHALL have exactly three states: IDLE, CLEAR_ALL, CLEAR_ROW.
REQ-016 char_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-017 A byte SHALL be accepted on a rising edge where char_valid and char_ready are both high; at most one byte per cycle.
REQ-018 All video_write_* outputs SHALL be registered; each write SHALL appear in the cycle after the accepting edge, with enable high for exactly one cycle.
REQ-019 Printable byte (any byte not 0x08, 0x0A, 0x0C, 0x0D): SHALL write the byte at (row, col), then col+1.
REQ-020 If col==COLS-1 when a printable byte is written, col SHALL become 0 and a row advance (REQ-024) SHALL follow.
REQ-021 0x0D (CR): SHALL set col=0 with no write.
REQ-022 0x0A (LF): SHALL set col=0 and perform a row advance.
REQ-023 0x08 (BS): if col>0, SHALL decrement col and write BLANK at the new position; if col==0, SHALL do nothing (no write, no row change).
REQ-024 Row advance: row SHALL become row+1, or 0 when row==ROWS-1. The state SHALL then go to CLEAR_ROW, which writes BLANK at columns 0..COLS-1 of the new row on COLS consecutive cycles, in ascending address order, then returns to IDLE.
REQ-025 0x0C (FF): SHALL set cursor to (0,0). The state SHALL then go to CLEAR_ALL, which writes BLANK at addresses 0..COLS*ROWS-1 on consecutive cycles, ascending, then returns to IDLE.
REQ-026 Address arithmetic SHALL be 11-bit unsigned; row*COLS SHALL be formed by shift-add (row<<5 + row<<4 + row<<1 for COLS=50) without a multiplier.
REQ-027 Cursor outputs SHALL reflect the post-update position from the cycle after acceptance.
REQ-028 char_valid while busy SHALL be ignored; the producer SHALL hold the byte until it is accepted.

Reset
REQ-029 Asserting resetn low SHALL, asynchronously, set cursor to (0,0), video_write_enable to 0, video_write_data to 0, video_write_addr to 0, and the clear counter to 0.
REQ-030 On release of reset, the state SHALL be CLEAR_ALL, so that the screen is blanked before the first byte is accepted.
REQ-031 Reset asserted in the middle of a clear SHALL abort it; after release, the clear SHALL restart from address 0.

Structure
REQ-032 A shared package SHALL define COLS, ROWS, BLANK, the control-code constants, and the state enum.
REQ-033 One sub-module, console_addr_gen (row, col -> 11-bit address), is natural; everything else SHALL be flat.

Verification
REQ-034 Reset released -> 1500 writes of 0x20 at addresses 0..1499 on consecutive cycles, then char_ready=1 with cursor (0,0).
REQ-035 After the reset clear, send 0x41 -> one write at address 0 with data 0x41; cursor_col=1.
REQ-036 Send 50 x 0x42 from (0,0) -> writes at addresses 0..49, then 50 BLANK writes at addresses 50..99 with char_ready=0; ends at cursor (1,0).
REQ-037 Cursor (29,7), send 0x0A -> cursor (0,0); BLANK written at addresses 0..49; no write at address 1457.
REQ-038 Cursor (2,3), send 0x08 -> write 0x20 at address 102, col=2; then at (2,0), send 0x08 -> no write, cursor unchanged.
REQ-039 Pulse resetn low at write 700 of an FF clear -> outputs zeroed at once; after release, the clear restarts at address 0 and runs 1500 writes.

Source files
------------

// File: rtl/console_writer_pkg.sv
// Shared constants and state encoding for the text console writer.
package console_writer_pkg;

  localparam int unsigned COLS  = 50;
  localparam int unsigned ROWS  = 30;
  localparam logic [7:0]  BLANK = 8'h20;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ALL,
    CLEAR_ROW
  } state_e;

endpackage

// File: rtl/console_addr_gen.sv
// Maps a (row, col) cursor position to its linear video memory cell address.
module console_addr_gen #(
  parameter int unsigned COLS = console_writer_pkg::COLS
) (
  input  logic [4:0]  row,
  input  logic [5:0]  col,
  output logic [10:0] addr
);

  logic [10:0] row_base;

  // row*COLS built from shifted copies of row, one per set bit of COLS
  always_comb begin
    row_base = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (((COLS >> i) & 32'd1) != 32'd0) begin
        row_base = row_base + (11'(row) << i);
      end
    end
    addr = row_base + 11'(col);
  end

endmodule

// File: rtl/console_writer.sv
// Byte-stream console: places characters into video memory, handles control
// codes, and blanks rows or the whole screen with a cell-per-cycle clear.
module console_writer #(
  parameter int unsigned COLS  = console_writer_pkg::COLS,
  parameter int unsigned ROWS  = console_writer_pkg::ROWS,
  parameter logic [7:0]  BLANK = console_writer_pkg::BLANK
) (
  input  logic        CLK_CPU,
  input  logic        resetn,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        video_write_enable,
  output logic [7:0]  video_write_data,
  output logic [10:0] video_write_addr,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  import console_writer_pkg::*;

  localparam logic [5:0]  LAST_COL     = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
  localparam logic [10:0] LAST_CELL    = 11'(COLS * ROWS - 1);
  localparam logic [10:0] LAST_ROW_CNT = 11'(COLS - 1);

  state_e      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [10:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [7:0]  data_q, data_d;
  logic [10:0] addr_q, addr_d;

  logic [5:0]  ag_col;
  logic [10:0] cell_addr;
  logic [4:0]  next_row;

  // One address generator serves the cursor cell, the cell left of it for
  // backspace, and the column sweep of a row clear.
  always_comb begin
    if (state_q == CLEAR_ROW) begin
      ag_col = cnt_q[5:0];
    end else if (char_data == CHR_BS) begin
      ag_col = col_q - 6'd1;
    end else begin
      ag_col = col_q;
    end
  end

  console_addr_gen #(.COLS(COLS)) u_addr_gen (
    .row  (row_q),
    .col  (ag_col),
    .addr (cell_addr)
  );

  assign next_row = (row_q == LAST_ROW) ? '0 : row_q + 5'd1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          case (char_data)
            CHR_CR: col_d = '0;
            CHR_LF: begin
              col_d   = '0;
              row_d   = next_row;
              cnt_d   = '0;
              state_d = CLEAR_ROW;
            end
            CHR_BS: begin
              if (col_q != '0) begin
                col_d  = col_q - 6'd1;
                we_d   = 1'b1;
                data_d = BLANK;
                addr_d = cell_addr;
              end
            end
            CHR_FF: begin
              row_d   = '0;
              col_d   = '0;
              cnt_d   = '0;
              state_d = CLEAR_ALL;
            end
            default: begin
              we_d   = 1'b1;
              data_d = char_data;
              addr_d = cell_addr;
              if (col_q == LAST_COL) begin
                col_d   = '0;
                row_d   = next_row;
                cnt_d   = '0;
                state_d = CLEAR_ROW;
              end else begin
                col_d = col_q + 6'd1;
              end
            end
          endcase
        end
      end
      CLEAR_ALL: begin
        we_d   = 1'b1;
        data_d = BLANK;
        addr_d = cnt_q;
        if (cnt_q == LAST_CELL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      CLEAR_ROW: begin
        we_d   = 1'b1;
        data_d = BLANK;
        addr_d = cell_addr;
        if (cnt_q == LAST_ROW_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLEAR_ALL;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign char_ready         = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign video_write_enable = we_q;
  assign video_write_data   = data_q;
  assign video_write_addr   = addr_q;
  assign cursor_col         = col_q;
  assign cursor_row         = row_q;

endmodule

// File: tb/tb_console_writer.sv
// Randomized and directed bench for console_writer against a cursor/screen model.
module tb_console_writer;

  localparam int COLS  = 50;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int BOUND = 5000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        video_write_enable;
  logic [7:0]  video_write_data;
  logic [10:0] video_write_addr;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  console_writer #(.COLS(50), .ROWS(30), .BLANK(8'h20)) dut (
    .CLK_CPU            (clk),
    .resetn             (resetn),
    .char_valid         (char_valid),
    .char_data          (char_data),
    .char_ready         (char_ready),
    .video_write_enable (video_write_enable),
    .video_write_data   (video_write_data),
    .video_write_addr   (video_write_addr),
    .cursor_col         (cursor_col),
    .cursor_row         (cursor_row),
    .busy               (busy)
  );

  typedef struct {int c; int a; int d;} wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t got[$];
  wr_t exp_q[$];
  int  m_row = 0, m_col = 0, exp_delay = 0, exp_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (video_write_enable === 1'b1)
      got.push_back('{cyc, int'(video_write_addr), int'(video_write_data)});

  function automatic void m_advance();
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) exp_q.push_back('{0, m_row * COLS + c, 32'h20});
    exp_busy += COLS;
  endfunction

  function automatic void m_apply(input logic [7:0] ch);
    exp_delay = 0;
    exp_busy  = 0;
    case (ch)
      8'h08: if (m_col > 0) begin
        m_col--;
        exp_q.push_back('{0, m_row * COLS + m_col, 32'h20});
      end
      8'h0D: m_col = 0;
      8'h0A: begin m_col = 0; exp_delay = 1; m_advance(); end
      8'h0C: begin
        m_row = 0; m_col = 0; exp_delay = 1; exp_busy = CELLS;
        for (int a = 0; a < CELLS; a++) exp_q.push_back('{0, a, 32'h20});
      end
      default: begin
        exp_q.push_back('{0, m_row * COLS + m_col, int'(ch)});
        m_col++;
        if (m_col == COLS) begin m_col = 0; m_advance(); end
      end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = b;
    while (char_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL accept_timeout byte %h never accepted", b);
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    char_valid = 1'b0;
    char_data  = 8'($urandom);
  endtask

  task automatic wait_idle(output int bc, output bit pair_bad);
    int n = 0;
    bc = 0;
    pair_bad = 0;
    while (char_ready !== 1'b1 && n < BOUND) begin
      if (busy !== ~char_ready) pair_bad = 1;
      bc++; n++;
      @(negedge clk);
    end
    if (busy !== ~char_ready) pair_bad = 1;
    if (n >= BOUND) begin
      checks++; errors++;
      $display("FAIL idle_timeout char_ready still low after %0d cycles", n);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_op(input string name, input int first, input int bc, input bit pair_bad);
    int bad;
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d expected %0d", name, got.size(), exp_q.size());
    end else begin
      bad = -1;
      foreach (got[i]) if (bad < 0 && (got[i].a != exp_q[i].a || got[i].d != exp_q[i].d)) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s write[%0d] got addr %0d data %h expected addr %0d data %h",
                 name, bad, got[bad].a, got[bad].d, exp_q[bad].a, exp_q[bad].d);
      end
    end
    if (got.size() > 0) begin
      checks++;
      bad = -1;
      foreach (got[i]) if (bad < 0 && got[i].c != first + i) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s write_timing write[%0d] at cycle %0d expected %0d",
                 name, bad, got[bad].c, first + bad);
      end
    end
    checks++;
    if (bc != exp_busy) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected %0d", name, bc, exp_busy);
    end
    checks++;
    if (pair_bad) begin
      errors++;
      $display("FAIL %s ready_busy got busy==char_ready expected complement", name);
    end
    checks++;
    if (cursor_row !== 5'(m_row) || cursor_col !== 6'(m_col)) begin
      errors++;
      $display("FAIL %s cursor got (%0d,%0d) expected (%0d,%0d)",
               name, cursor_row, cursor_col, m_row, m_col);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_byte(input logic [7:0] b, input string name);
    int acc, bc;
    bit pb;
    got.delete();
    exp_q.delete();
    m_apply(b);
    send_byte(b, acc);
    wait_idle(bc, pb);
    check_op(name, acc + exp_delay, bc, pb);
  endtask

  // Hold reset, check cleared outputs, then release and expect a full blanking.
  task automatic reset_and_clear(input string name);
    int first, bc;
    bit pb;
    resetn = 1'b0;
    char_valid = 1'b0;
    #1;
    checks++;
    if (video_write_enable !== 1'b0 || video_write_data !== 8'h00 || video_write_addr !== 11'd0 ||
        cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL %s reset_outputs got we %b data %h addr %0d cursor (%0d,%0d) expected all zero",
               name, video_write_enable, video_write_data, video_write_addr, cursor_row, cursor_col);
    end
    repeat (2) @(negedge clk);
    got.delete();
    exp_q.delete();
    m_row = 0; m_col = 0; exp_busy = CELLS;
    for (int a = 0; a < CELLS; a++) exp_q.push_back('{0, a, 32'h20});
    resetn = 1'b1;
    first = cyc + 1;
    wait_idle(bc, pb);
    check_op(name, first, bc, pb);
  endtask

  task automatic test_reset;
    reset_and_clear("reset_clear");
  endtask

  task automatic test_print_one;
    do_byte(8'h41, "print_A");
    checks++;
    if (cursor_col !== 6'd1) begin
      errors++;
      $display("FAIL print_A_col got %0d expected 1", cursor_col);
    end
  endtask

  task automatic test_wrap;
    do_byte(8'h0C, "ff_home");
    for (int i = 0; i < COLS; i++) do_byte(8'h42, "wrap_B");
    checks++;
    if (cursor_row !== 5'd1 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL wrap_end got (%0d,%0d) expected (1,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_lf_bottom;
    do_byte(8'h0C, "ff_home");
    for (int i = 0; i < ROWS - 1; i++) do_byte(8'h0A, "lf_down");
    for (int i = 0; i < 7; i++) do_byte(8'h2E, "dots");
    checks++;
    if (cursor_row !== 5'd29 || cursor_col !== 6'd7) begin
      errors++;
      $display("FAIL bottom_pos got (%0d,%0d) expected (29,7)", cursor_row, cursor_col);
    end
    do_byte(8'h0A, "lf_wrap_top");
  endtask

  task automatic test_backspace;
    do_byte(8'h0C, "ff_home");
    do_byte(8'h0A, "lf");
    do_byte(8'h0A, "lf");
    for (int i = 0; i < 3; i++) do_byte(8'h61, "bs_setup");
    do_byte(8'h08, "bs_mid");
    do_byte(8'h0D, "cr");
    do_byte(8'h08, "bs_col0");
    checks++;
    if (cursor_row !== 5'd2 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL bs_col0_pos got (%0d,%0d) expected (2,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_reset_mid_clear;
    int acc, n;
    got.delete();
    send_byte(8'h0C, acc);
    n = 0;
    while (got.size() < 700 && n < BOUND) begin @(negedge clk); n++; end
    checks++;
    if (got.size() < 700) begin
      errors++;
      $display("FAIL midclear_progress got %0d writes expected 700", got.size());
    end
    #2;
    reset_and_clear("midclear_restart");
  endtask

  task automatic test_random;
    logic [7:0] b;
    int r;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       b = 8'h0C;
      else if (r < 12) b = 8'h0A;
      else if (r < 18) b = 8'h0D;
      else if (r < 30) b = 8'h08;
      else if (r < 90) b = 8'($urandom_range(32, 126));
      else begin
        b = 8'($urandom);
        if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'hFF;
      end
      do_byte(b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_print_one();
    test_wrap();
    test_lf_bottom();
    test_backspace();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
